// File: rtl/ram_playback_ctrl_pkg.sv
// Shared types and constants for the RAM playback controller.
package playback_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHOW, ST_DONE} pb_state_t;

  // Short dwell so a simulated playback finishes in a handful of cycles
  localparam int DWELL_SIM = 4;

endpackage

// File: rtl/ram_playback_ctrl_if.sv
// Start request, RAM read port and display outputs of the playback controller.
interface ram_playback_ctrl_if #(
  parameter int n = 4,
  parameter int m = 8
);

  logic         btn;
  logic [n-1:0] num_valid;
  logic [m-1:0] rd_data;
  logic [n-1:0] rd_addr;
  logic [m-1:0] disp_val;
  logic [n-1:0] disp_idx;
  logic [m-1:0] max_val;
  logic         busy;
  logic         done;

  modport master (
    output btn, num_valid, rd_data,
    input  rd_addr, disp_val, disp_idx, max_val, busy, done
  );

  modport slave (
    input  btn, num_valid, rd_data,
    output rd_addr, disp_val, disp_idx, max_val, busy, done
  );

endinterface

// File: rtl/ram_playback_ctrl_dwell_timer.sv
// Per-entry dwell timer; expire marks the last cycle an entry stays on display.
module dwell_timer #(
  parameter int DWELL = 50000000
) (
  input  logic clk,
  input  logic clr,
  input  logic rst_cnt,
  input  logic en,
  output logic expire
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] TC = CW'(DWELL - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr || rst_cnt) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ONE;
    end
  end

  assign expire = en && (cnt == TC);

endmodule

// File: rtl/ram_playback_ctrl.sv
// Plays stored averages back in address order, holding each for DWELL cycles
// and tracking the running maximum of the values shown.
module ram_playback_ctrl
  import playback_pkg::*;
#(
  parameter int n     = 4,
  parameter int m     = 8,
  parameter int DWELL = 50000000
) (
  input logic               clk,
  input logic               clr,
  ram_playback_ctrl_if.slave bus
);

  localparam logic [n-1:0] ONE = n'(1);

  pb_state_t    state, state_next;
  logic         btn_q;
  logic [n-1:0] lim, lim_next;
  logic [n-1:0] addr, addr_next;
  logic [m-1:0] disp_val, disp_val_next;
  logic [n-1:0] disp_idx, disp_idx_next;
  logic [m-1:0] max_val, max_val_next;
  logic         busy, busy_next;
  logic         done, done_next;
  logic         start;
  logic         rst_cnt;
  logic         en;
  logic         expire;

  dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk     (clk),
    .clr     (clr),
    .rst_cnt (rst_cnt),
    .en      (en),
    .expire  (expire)
  );

  assign start = bus.btn & ~btn_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_IDLE;
      btn_q    <= 1'b0;
      lim      <= '0;
      addr     <= '0;
      disp_val <= '0;
      disp_idx <= '0;
      max_val  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      btn_q    <= bus.btn;
      lim      <= lim_next;
      addr     <= addr_next;
      disp_val <= disp_val_next;
      disp_idx <= disp_idx_next;
      max_val  <= max_val_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    lim_next      = lim;
    addr_next     = addr;
    disp_val_next = disp_val;
    disp_idx_next = disp_idx;
    max_val_next  = max_val;
    busy_next     = busy;
    done_next     = 1'b0;
    rst_cnt       = 1'b0;
    en            = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lim_next     = bus.num_valid;
          addr_next    = '0;
          max_val_next = '0;
          if (bus.num_valid == '0) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_LOAD;
            busy_next  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        disp_val_next = bus.rd_data;
        disp_idx_next = addr;
        if (bus.rd_data > max_val) begin
          max_val_next = bus.rd_data;
        end
        rst_cnt    = 1'b1;
        state_next = ST_SHOW;
      end
      ST_SHOW: begin
        en = 1'b1;
        if (expire) begin
          // Stop on the last latched entry; the address never runs past lim-1
          if (addr == lim - ONE) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end else begin
            addr_next  = addr + ONE;
            state_next = ST_LOAD;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.rd_addr  = addr;
  assign bus.disp_val = disp_val;
  assign bus.disp_idx = disp_idx;
  assign bus.max_val  = max_val;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule

// File: tb/tb_ram_playback_ctrl.sv
// Directed bench for ram_playback_ctrl with DWELL=4, n=4, m=8.
module tb_ram_playback_ctrl;
  import playback_pkg::*;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] ram [16];
  int         vec = 0;
  int         err = 0;

  ram_playback_ctrl_if #(.n(4), .m(8)) bus ();

  assign bus.rd_data = ram[bus.rd_addr];

  ram_playback_ctrl #(.n(4), .m(8), .DWELL(DWELL_SIM)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ram3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int i = 0; i < 16; i++) ram[i] = 8'd0;
    ram[0] = a;
    ram[1] = b;
    ram[2] = c;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.btn = 1'b1;
    bus.num_valid = 4'd3;
    step();
    step();
    vec++;
    if (dut.state !== ST_IDLE || bus.rd_addr !== 4'd0 || bus.disp_val !== 8'd0 ||
        bus.disp_idx !== 4'd0 || bus.max_val !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      err++;
      $display("FAIL reset_state: state=%s addr=%0d val=%0d idx=%0d max=%0d busy=%b done=%b, want all 0/IDLE",
               dut.state.name(), bus.rd_addr, bus.disp_val, bus.disp_idx, bus.max_val, bus.busy, bus.done);
    end
    clr = 1'b0;
    bus.btn = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      vec++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || dut.state !== ST_IDLE) begin
        err++;
        $display("FAIL reset_no_start c=%0d: busy=%b done=%b state=%s, want 0 0 IDLE",
                 c, bus.busy, bus.done, dut.state.name());
      end
    end
  endtask

  task automatic test_playback();
    logic [7:0] ev [3];
    logic [7:0] em [3];
    int k, ea;
    logic exp_busy, exp_done;
    ev = '{8'd20, 8'd17, 8'd31};
    em = '{8'd20, 8'd20, 8'd31};
    load_ram3(8'd20, 8'd17, 8'd31);
    bus.num_valid = 4'd3;
    bus.btn = 1'b1;
    step();
    vec++;
    if (bus.busy !== 1'b1 || bus.rd_addr !== 4'd0 || bus.done !== 1'b0) begin
      err++;
      $display("FAIL play_start: busy=%b addr=%0d done=%b, want 1 0 0", bus.busy, bus.rd_addr, bus.done);
    end
    bus.btn = 1'b0;
    bus.num_valid = 4'd9;  // must be ignored mid-playback
    for (int c = 1; c <= 16; c++) begin
      step();
      k        = (c > 15) ? 2 : (c - 1) / 5;
      ea       = (c / 5 > 2) ? 2 : c / 5;
      exp_done = (c == 15);
      exp_busy = (c < 15);
      vec++;
      if (bus.disp_val !== ev[k] || bus.disp_idx !== 4'(k) || bus.max_val !== em[k] ||
          bus.rd_addr !== 4'(ea) || bus.busy !== exp_busy || bus.done !== exp_done) begin
        err++;
        $display("FAIL play_cycle c=%0d: val=%0d idx=%0d max=%0d addr=%0d busy=%b done=%b, want %0d %0d %0d %0d %b %b",
                 c, bus.disp_val, bus.disp_idx, bus.max_val, bus.rd_addr, bus.busy, bus.done,
                 ev[k], k, em[k], ea, exp_busy, exp_done);
      end
    end
  endtask

  task automatic test_zero_entries();
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    bus.num_valid = 4'd0;
    bus.btn = 1'b1;
    step();
    vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      err++;
      $display("FAIL zero_done: busy=%b done=%b, want 0 1", bus.busy, bus.done);
    end
    bus.btn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      vec++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.disp_val !== 8'd0 ||
          bus.disp_idx !== 4'd0 || bus.max_val !== 8'd0) begin
        err++;
        $display("FAIL zero_hold c=%0d: busy=%b done=%b val=%0d idx=%0d max=%0d, want all 0",
                 c, bus.busy, bus.done, bus.disp_val, bus.disp_idx, bus.max_val);
      end
    end
  endtask

  task automatic test_btn_hold();
    int done_cnt, done_cycle, busy_rises;
    logic prev_busy;
    bit got;
    load_ram3(8'd5, 8'd9, 8'd3);
    bus.num_valid = 4'd3;
    bus.btn = 1'b1;
    step();
    done_cnt = 0; done_cycle = 0; busy_rises = 0; prev_busy = bus.busy;
    for (int c = 1; c <= 40; c++) begin
      if (c == 8) bus.btn = 1'b0;
      if (c == 9) bus.btn = 1'b1;
      step();
      if (bus.busy && !prev_busy) busy_rises++;
      if (bus.done) begin
        done_cnt++;
        if (done_cycle == 0) done_cycle = c;
      end
      prev_busy = bus.busy;
    end
    vec++;
    if (done_cnt !== 1 || done_cycle !== 15 || busy_rises !== 0 || bus.busy !== 1'b0) begin
      err++;
      $display("FAIL hold_single: done_cnt=%0d done_cycle=%0d busy_rises=%0d busy=%b, want 1 15 0 0",
               done_cnt, done_cycle, busy_rises, bus.busy);
    end
    bus.btn = 1'b0;
    step();
    bus.btn = 1'b1;
    step();
    vec++;
    if (bus.busy !== 1'b1 || bus.rd_addr !== 4'd0) begin
      err++;
      $display("FAIL hold_restart: busy=%b addr=%0d, want 1 0", bus.busy, bus.rd_addr);
    end
    bus.btn = 1'b0;
    step();
    vec++;
    if (bus.disp_idx !== 4'd0 || bus.disp_val !== 8'd5 || bus.max_val !== 8'd5) begin
      err++;
      $display("FAIL hold_first: idx=%0d val=%0d max=%0d, want 0 5 5", bus.disp_idx, bus.disp_val, bus.max_val);
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (bus.done) got = 1'b1;
    end
    vec++;
    if (!got || bus.max_val !== 8'd9 || bus.disp_val !== 8'd3 || bus.disp_idx !== 4'd2) begin
      err++;
      $display("FAIL hold_second: done_seen=%b max=%0d val=%0d idx=%0d, want 1 9 3 2",
               got, bus.max_val, bus.disp_val, bus.disp_idx);
    end
  endtask

  task automatic test_full_range();
    int max_addr, done_cycle;
    for (int i = 0; i < 15; i++) ram[i] = 8'(16 + i);
    ram[15] = 8'hFF;
    bus.num_valid = 4'd15;
    bus.btn = 1'b1;
    step();
    bus.btn = 1'b0;
    max_addr = 0; done_cycle = 0;
    for (int c = 1; c <= 90; c++) begin
      step();
      if (int'(bus.rd_addr) > max_addr) max_addr = int'(bus.rd_addr);
      if (bus.done && done_cycle == 0) done_cycle = c;
    end
    vec++;
    if (max_addr !== 14 || done_cycle !== 75) begin
      err++;
      $display("FAIL full_addr: max_addr=%0d done_cycle=%0d, want 14 75", max_addr, done_cycle);
    end
    vec++;
    if (bus.max_val !== 8'd30 || bus.disp_val !== 8'd30 || bus.disp_idx !== 4'd14) begin
      err++;
      $display("FAIL full_values: max=%0d val=%0d idx=%0d, want 30 30 14", bus.max_val, bus.disp_val, bus.disp_idx);
    end
  endtask

  task automatic test_abort();
    int done_cnt, busy_cnt;
    load_ram3(8'd20, 8'd17, 8'd31);
    bus.num_valid = 4'd3;
    bus.btn = 1'b1;
    step();
    bus.btn = 1'b0;
    for (int c = 1; c <= 7; c++) step();
    vec++;
    if (dut.state !== ST_SHOW || bus.disp_idx !== 4'd1 || bus.disp_val !== 8'd17) begin
      err++;
      $display("FAIL abort_pre: state=%s idx=%0d val=%0d, want SHOW 1 17", dut.state.name(), bus.disp_idx, bus.disp_val);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    vec++;
    if (dut.state !== ST_IDLE || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_addr !== 4'd0 ||
        bus.disp_val !== 8'd0 || bus.max_val !== 8'd0) begin
      err++;
      $display("FAIL abort_idle: state=%s busy=%b done=%b addr=%0d val=%0d max=%0d, want IDLE 0 0 0 0 0",
               dut.state.name(), bus.busy, bus.done, bus.rd_addr, bus.disp_val, bus.max_val);
    end
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cnt++;
    end
    vec++;
    if (done_cnt !== 0 || busy_cnt !== 0) begin
      err++;
      $display("FAIL abort_quiet: done_cnt=%0d busy_cnt=%0d, want 0 0", done_cnt, busy_cnt);
    end
    bus.btn = 1'b1;
    step();
    bus.btn = 1'b0;
    vec++;
    if (bus.busy !== 1'b1 || bus.rd_addr !== 4'd0) begin
      err++;
      $display("FAIL abort_restart: busy=%b addr=%0d, want 1 0", bus.busy, bus.rd_addr);
    end
    step();
    vec++;
    if (bus.disp_idx !== 4'd0 || bus.disp_val !== 8'd20 || bus.max_val !== 8'd20) begin
      err++;
      $display("FAIL abort_replay: idx=%0d val=%0d max=%0d, want 0 20 20", bus.disp_idx, bus.disp_val, bus.max_val);
    end
  endtask

  initial begin
    bus.btn = 1'b0;
    bus.num_valid = 4'd0;
    for (int i = 0; i < 16; i++) ram[i] = 8'd0;
    test_reset();
    test_playback();
    test_zero_entries();
    test_btn_hold();
    test_full_range();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
